// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin arbiter sharing one registered bitwise logic unit among N_REQ requesters.
// Define LOGIC_OP_ARBITER_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module logic_op_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2:0]             rsp_op
`ifdef LOGIC_OP_ARBITER_STATS_EN
  ,
  output logic [16*N_REQ-1:0]    grant_cnt
`endif
);

  typedef enum logic {IDLE, RESP} state_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_t;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    y = a;
    case (op_t'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
    endcase
    return y;
  endfunction

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr, rr_next;
  logic [ID_W-1:0] grant_idx, cand;
  logic            grant_any, can_accept, accept;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Rotating priority scan starting at rr_ptr; first valid requester wins.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign can_accept = !rst && ((state == IDLE) || rsp_ready);
  assign accept     = can_accept && grant_any;
  assign rr_next    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  assign sel_op = req_op[int'(grant_idx)*3 +: 3];
  assign sel_a  = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b  = req_b[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RESP;
      RESP:    if (rsp_ready && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign rsp_valid = (state == RESP);

  // Result registers only load on a grant, so they hold while the consumer stalls or after draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_op   <= '0;
    end else if (accept) begin
      rr_ptr   <= rr_next;
      rsp_data <= logic_fn(sel_op, sel_a, sel_b);
      rsp_id   <= grant_idx;
      rsp_op   <= sel_op;
    end
  end

`ifdef LOGIC_OP_ARBITER_STATS_EN
  logic [15:0] cnt_q [N_REQ];

  // NOTE: this counter array is a handful of flops, not a RAM macro, so a full reset is legitimate here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[grant_idx] != 16'hFFFF)) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[16*i +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one registered bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT/BUF) between N_REQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Sits in front of the gate-level datapath: sequences operand/opcode delivery, tags each result with the originating requester.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(N_REQ), requester-ID width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_op  in  3*N_REQ  opcode, slice i = requester i.
- req_a  in  WIDTH*N_REQ  operand A, slice i.
- req_b  in  WIDTH*N_REQ  operand B, slice i.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  result.
- rsp_id  out  ID_W  index of requester that issued the result.
- rsp_op  out  3  opcode that produced the result.

Behaviour:
- Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT (~a, b ignored), 7 BUF (a, b ignored).
- FSM states IDLE, RESP. Reset -> IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_op=0.
- can_accept = (state==IDLE) | (state==RESP & rsp_ready).
- Arbitration (combinational): when can_accept and any req_valid, grant g = first valid index scanning rr_ptr, rr_ptr+1, ... mod N_REQ; req_ready[g]=1, all others 0. If !can_accept, req_ready=0.
- Handshake on requester i completes when req_valid[i] & req_ready[i]; opcode/operands sampled that edge; result computed and registered same edge -> rsp_valid=1 next cycle (latency 1).
- On grant: rr_ptr <= (g+1) mod N_REQ; state <= RESP.
- RESP: rsp_valid=1; rsp_data/rsp_id/rsp_op held stable until rsp_valid & rsp_ready.
- RESP & rsp_ready & new grant (simultaneous): old result retires, new result loads, rsp_valid stays 1 -> sustained throughput one op/cycle.
- RESP & rsp_ready & no request: state <= IDLE, rsp_valid <= 0; rsp_data/rsp_id/rsp_op retain last value.
- Wrap-around: rr_ptr at N_REQ-1 with grant wraps to 0.
- Single persistent requester with others idle: granted every accept cycle (no bubbles inserted).
- req_valid deasserted before grant: request is dropped with no side effects; no state holds unaccepted requests.
- Reset mid-operation (any state): next cycle IDLE, rsp_valid=0, pending result discarded, rr_ptr=0; req_ready=0 during the reset cycle.
- Requesters must hold req_op/a/b stable while req_valid is high and unaccepted (bench asserts this).

Optional Feature:
- Macro LOGIC_OP_ARBITER_STATS_EN.
- Defined: extra output grant_cnt (16*N_REQ). Slice i is a saturating grant counter for requester i: +1 per completed handshake; holds at 16'hFFFF; cleared by rst.
- Undefined: port absent; no counter logic.

Test Plan:
- Ops sweep: requester 0 only, a=8'hF0, b=8'hCC, ops 0..7 back-to-back, rsp_ready=1 -> rsp_data C0, FC, 3F, 03, 3C, C3, 0F, F0 on consecutive cycles, rsp_id=0.
- Round-robin: all 4 req_valid held high, rsp_ready=1 from reset -> grant/rsp_id order 0,1,2,3,0,1. Each requester is granted exactly once per 4 accepts.
- Backpressure: grant req 2 (op XOR, a=8'hAA, b=8'hFF), rsp_ready=0 for 5 cycles -> rsp_valid=1 with rsp_data=8'h55 stable, req_ready all 0. rsp_ready=1 -> req 3 granted that same cycle.
- Pointer wrap/skip: rr_ptr=3 after granting 2; only req 1 valid -> req 1 granted; rr_ptr becomes 2.
- Reset mid-op: assert rst while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0. After release, all valid -> first grant to req 0.
- Stats (LOGIC_OP_ARBITER_STATS_EN): 10 grants to req 1 -> grant_cnt slice 1 = 10, other slices = 0. After rst -> all slices = 0.
